// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared helpers for the gshare/bimodal branch predictor:
//   - PC field extraction (index and tag) for any index/tag width
//   - counter reset/allocate constants as functions of the counter width
// The table entry struct is declared inside the top because its field widths
// follow the top's parameters.
// -----------------------------------------------------------------------------
package bp_pkg;

  // Widest PC the extraction helpers accept; callers cast their PC up to this.
  localparam int BP_PC_MAX_W = 64;

  // Weak-not-taken: 2^(ctr_w-1)-1 (01 for a 2-bit counter, 0 for 1-bit).
  function automatic int bp_ctr_weak_nt(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  // Weak-taken: 2^(ctr_w-1) (10 for a 2-bit counter, 1 for 1-bit).
  function automatic int bp_ctr_weak_t(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // Index field: pc[idx_w+1:2] (word-aligned PCs, bits [1:0] ignored).
  function automatic logic [BP_PC_MAX_W-1:0] bp_pc_index(
    input logic [BP_PC_MAX_W-1:0] pc,
    input int                     idx_w
  );
    logic [BP_PC_MAX_W-1:0] mask;
    mask = (BP_PC_MAX_W'(1) << idx_w) - BP_PC_MAX_W'(1);
    return (pc >> 2) & mask;
  endfunction

  // Tag field: pc[tag_w+idx_w+1:idx_w+2], directly above the index field.
  function automatic logic [BP_PC_MAX_W-1:0] bp_pc_tag(
    input logic [BP_PC_MAX_W-1:0] pc,
    input int                     idx_w,
    input int                     tag_w
  );
    logic [BP_PC_MAX_W-1:0] mask;
    mask = (BP_PC_MAX_W'(1) << tag_w) - BP_PC_MAX_W'(1);
    return (pc >> (idx_w + 2)) & mask;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// -----------------------------------------------------------------------------
// bp_sat_ctr
// Combinational next-value of a saturating up/down counter.
// Ports:
//   i_ctr    current counter value
//   i_taken  1 = count up (saturate at all-ones), 0 = count down (saturate at 0)
//   o_ctr    next counter value
// -----------------------------------------------------------------------------
module bp_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != {CTR_W{1'b1}}) o_ctr = i_ctr + CTR_W'(1);
    end else begin
      if (i_ctr != {CTR_W{1'b0}}) o_ctr = i_ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/br_predictor_gshare.sv
// -----------------------------------------------------------------------------
// br_predictor_gshare
// Tagged branch target buffer with saturating direction counters. MODE 0
// indexes with the PC index field (bimodal); MODE 1 XORs that field with a
// non-speculative global history register (gshare).
// Ports:
//   CLK             clock, rising edge
//   nRST            synchronous active-low reset
//   lookup_pc       fetch PC (combinational lookup)
//   predict_hit     valid entry with matching tag
//   predict_taken   hit and counter MSB set
//   predict_target  stored target on hit, else 0
//   predict_index   table index used; carried down the pipeline
//   update_valid    a branch resolved this cycle
//   update_pc       PC of the resolved branch (supplies the tag)
//   update_index    predict_index captured at that branch's lookup
//   update_taken    actual outcome
//   update_target   actual taken target
// -----------------------------------------------------------------------------
module br_predictor_gshare
  import bp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int MODE    = 0,
  parameter int GHR_W   = IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             predict_hit,
  output logic             predict_taken,
  output logic [PC_W-1:0]  predict_target,
  output logic [IDX_W-1:0] predict_index,
  input  logic             update_valid,
  input  logic [PC_W-1:0]  update_pc,
  input  logic [IDX_W-1:0] update_index,
  input  logic             update_taken,
  input  logic [PC_W-1:0]  update_target
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } bp_entry_t;

  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(bp_ctr_weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(bp_ctr_weak_t(CTR_W));

  bp_entry_t        r_table [ENTRIES];
  logic [GHR_W-1:0] r_ghr;

  logic [IDX_W-1:0] w_lk_field;
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  bp_entry_t        w_lk_entry;
  logic             w_lk_hit;

  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [CTR_W-1:0] w_up_ctr;
  logic [CTR_W-1:0] w_up_ctr_next;

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational, reads pre-update contents (no bypass).
  // ---------------------------------------------------------------------------
  assign w_lk_field = IDX_W'(bp_pc_index(BP_PC_MAX_W'(lookup_pc), IDX_W));
  assign w_lk_tag   = TAG_W'(bp_pc_tag(BP_PC_MAX_W'(lookup_pc), IDX_W, TAG_W));
  // Shorter history is zero-extended into the low index bits.
  assign w_lk_idx   = (MODE == 1) ? (w_lk_field ^ IDX_W'(r_ghr)) : w_lk_field;
  assign w_lk_entry = r_table[w_lk_idx];
  assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

  assign predict_index  = w_lk_idx;
  assign predict_hit    = w_lk_hit;
  assign predict_taken  = w_lk_hit & w_lk_entry.ctr[CTR_W-1];
  assign predict_target = w_lk_hit ? w_lk_entry.target : '0;

  // ---------------------------------------------------------------------------
  // Update path: the index comes from the pipeline, the tag from update_pc.
  // ---------------------------------------------------------------------------
  assign w_up_tag = TAG_W'(bp_pc_tag(BP_PC_MAX_W'(update_pc), IDX_W, TAG_W));
  assign w_up_hit = r_table[update_index].valid &&
                    (r_table[update_index].tag == w_up_tag);
  assign w_up_ctr = r_table[update_index].ctr;

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .i_ctr   (w_up_ctr),
    .i_taken (update_taken),
    .o_ctr   (w_up_ctr_next)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i].valid  <= 1'b0;
        r_table[i].tag    <= '0;
        r_table[i].target <= '0;
        r_table[i].ctr    <= CTR_WEAK_NT;
      end
    end else if (update_valid) begin
      if (w_up_hit) begin
        r_table[update_index].ctr <= w_up_ctr_next;
        if (update_taken) r_table[update_index].target <= update_target;
      end else if (update_taken) begin
        // Allocation overwrites whatever aliased entry sits at this index.
        r_table[update_index].valid  <= 1'b1;
        r_table[update_index].tag    <= w_up_tag;
        r_table[update_index].target <= update_target;
        r_table[update_index].ctr    <= CTR_WEAK_T;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Global history: shifted on every resolved branch, gshare only.
  // ---------------------------------------------------------------------------
  generate
    if (MODE == 1) begin : g_ghr
      logic [GHR_W-1:0] w_ghr_next;
      if (GHR_W == 1) begin : g_ghr1
        assign w_ghr_next = update_taken;
      end else begin : g_ghrn
        assign w_ghr_next = {r_ghr[GHR_W-2:0], update_taken};
      end
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          r_ghr <= '0;
        end else if (update_valid) begin
          r_ghr <= w_ghr_next;
        end
      end
    end else begin : g_no_ghr
      assign r_ghr = '0;
    end
  endgenerate

endmodule

// File: tb/tb_br_predictor_gshare.sv
// -----------------------------------------------------------------------------
// tb_br_predictor_gshare
// Drives a bimodal instance (u_dut0) and a gshare instance with a 4-bit
// history (u_dut1) from one shared stimulus stream and compares both against
// a table model built from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_br_predictor_gshare;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [3:0]  uidx0, uidx1;

  logic        hit0, tk0, hit1, tk1;
  logic [31:0] tgt0, tgt1;
  logic [3:0]  pidx0, pidx1;

  br_predictor_gshare #(.MODE(0)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .predict_hit(hit0), .predict_taken(tk0), .predict_target(tgt0),
    .predict_index(pidx0), .update_valid(update_valid), .update_pc(update_pc),
    .update_index(uidx0), .update_taken(update_taken),
    .update_target(update_target)
  );

  br_predictor_gshare #(.MODE(1), .GHR_W(4)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .predict_hit(hit1), .predict_taken(tk1), .predict_target(tgt1),
    .predict_index(pidx1), .update_valid(update_valid), .update_pc(update_pc),
    .update_index(uidx1), .update_taken(update_taken),
    .update_target(update_target)
  );

  int checks = 0;
  int errors = 0;

  // Model: 16 entries, 8-bit tags, counters 0..3, 4-bit history.
  bit          m_valid [2][16];
  int          m_tag   [2][16];
  logic [31:0] m_tgt   [2][16];
  int          m_ctr   [2][16];
  int          m_ghr   [2];

  function automatic int m_idx(int m, logic [31:0] pc);
    int f;
    f = int'((pc / 4) % 16);
    return (m == 1) ? (f ^ m_ghr[1]) : f;
  endfunction

  function automatic int m_tagof(logic [31:0] pc);
    return int'((pc / 64) % 256);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int m = 0; m < 2; m++) begin
      int          idx;
      bit          h;
      bit          t;
      logic [31:0] tg;
      idx = m_idx(m, lookup_pc);
      h   = m_valid[m][idx] && (m_tag[m][idx] == m_tagof(lookup_pc));
      t   = h && (m_ctr[m][idx] >= 2);
      tg  = h ? m_tgt[m][idx] : 32'h0;
      chk($sformatf("%s.m%0d.idx", tag, m), (m == 1) ? 32'(pidx1) : 32'(pidx0), 32'(idx));
      chk($sformatf("%s.m%0d.hit", tag, m), (m == 1) ? 32'(hit1) : 32'(hit0), 32'(h));
      chk($sformatf("%s.m%0d.tk", tag, m), (m == 1) ? 32'(tk1) : 32'(tk0), 32'(t));
      chk($sformatf("%s.m%0d.tgt", tag, m), (m == 1) ? tgt1 : tgt0, tg);
    end
  endtask

  task automatic model_clock();
    for (int m = 0; m < 2; m++) begin
      if (!nRST) begin
        for (int i = 0; i < 16; i++) begin
          m_valid[m][i] = 1'b0;
          m_tag[m][i]   = 0;
          m_tgt[m][i]   = 32'h0;
          m_ctr[m][i]   = 1;
        end
        m_ghr[m] = 0;
      end else if (update_valid) begin
        int idx;
        idx = (m == 1) ? int'(uidx1) : int'(uidx0);
        if (m_valid[m][idx] && (m_tag[m][idx] == m_tagof(update_pc))) begin
          if (update_taken) begin
            m_ctr[m][idx] = (m_ctr[m][idx] == 3) ? 3 : m_ctr[m][idx] + 1;
            m_tgt[m][idx] = update_target;
          end else begin
            m_ctr[m][idx] = (m_ctr[m][idx] == 0) ? 0 : m_ctr[m][idx] - 1;
          end
        end else if (update_taken) begin
          m_valid[m][idx] = 1'b1;
          m_tag[m][idx]   = m_tagof(update_pc);
          m_tgt[m][idx]   = update_target;
          m_ctr[m][idx]   = 2;
        end
        if (m == 1) m_ghr[m] = ((m_ghr[m] * 2) + int'(update_taken)) % 16;
      end
    end
  endtask

  // One cycle: drive after the falling edge, check mid-cycle, clock the model.
  task automatic cyc(string tag, bit do_chk, logic [31:0] lpc, logic rst_n,
                     logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt);
    lookup_pc     = lpc;
    nRST          = rst_n;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    uidx0         = 4'(m_idx(0, upc));
    uidx1         = 4'(m_idx(1, upc));
    #1;
    if (do_chk) check_all(tag);
    @(posedge CLK);
    model_clock();
    @(negedge CLK);
  endtask

  task automatic peek(logic [31:0] lpc);
    lookup_pc    = lpc;
    update_valid = 1'b0;
    #1;
  endtask

  initial begin
    nRST = 1'b0; lookup_pc = '0; update_valid = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_target = '0; uidx0 = '0; uidx1 = '0;
    @(negedge CLK);

    // 1: reset, then all outputs zero
    cyc("rst", 1'b0, 32'h40, 1'b0, 1'b0, 0, 1'b0, 0);
    peek(32'h40);
    chk("s1.hit", 32'(hit0), 0);
    chk("s1.tk", 32'(tk0), 0);
    chk("s1.tgt", tgt0, 0);
    chk("s1.idx", 32'(pidx0), 0);
    chk("s1.idx1", 32'(pidx1), 0);
    check_all("s1");

    // 2: allocate 0x40 -> target 0x100, weak-taken
    cyc("s2u", 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100);
    peek(32'h40);
    chk("s2.hit", 32'(hit0), 1);
    chk("s2.tk", 32'(tk0), 1);
    chk("s2.tgt", tgt0, 32'h100);
    cyc("s2", 1'b1, 32'h40, 1'b1, 1'b0, 0, 1'b0, 0);

    // 3: three not-taken updates, counter saturates at 0
    for (int k = 0; k < 3; k++)
      cyc($sformatf("s3.%0d", k), 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 0);
    peek(32'h40);
    chk("s3.hit", 32'(hit0), 1);
    chk("s3.tk", 32'(tk0), 0);
    cyc("s3.a", 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h104);
    peek(32'h40);
    chk("s3.nowrap", 32'(tk0), 0);

    // 4: aliasing at index 0
    cyc("s4.a", 1'b1, 32'h440, 1'b1, 1'b0, 0, 1'b0, 0);
    cyc("s4.u", 1'b1, 32'h440, 1'b1, 1'b1, 32'h440, 1'b1, 32'h200);
    peek(32'h40);
    chk("s4.old", 32'(hit0), 0);
    cyc("s4.b", 1'b1, 32'h40, 1'b1, 1'b0, 0, 1'b0, 0);
    peek(32'h440);
    chk("s4.new", tgt0, 32'h200);
    cyc("s4.c", 1'b1, 32'h440, 1'b1, 1'b0, 0, 1'b0, 0);

    // 5: same-cycle lookup/update, then reset swallowing an update
    cyc("s5.a", 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h104);
    cyc("s5.b", 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h104);
    cyc("s5.c", 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 0);
    peek(32'h40);
    chk("s5.still", 32'(tk0), 1);
    cyc("s5.d", 1'b1, 32'h40, 1'b1, 1'b0, 0, 1'b0, 0);
    cyc("s5.r", 1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h108);
    peek(32'h40);
    chk("s5.clr", 32'(hit0), 0);
    cyc("s5.e", 1'b1, 32'h40, 1'b1, 1'b0, 0, 1'b0, 0);

    // 6: gshare history
    cyc("s6.a", 1'b1, 32'h0, 1'b1, 1'b1, 32'h44, 1'b1, 32'h10);
    cyc("s6.b", 1'b1, 32'h0, 1'b1, 1'b1, 32'h48, 1'b1, 32'h14);
    cyc("s6.c", 1'b1, 32'h0, 1'b1, 1'b1, 32'h4C, 1'b0, 0);
    peek(32'h40);
    chk("s6.idx6", 32'(pidx1), 6);
    chk("s6.idx0", 32'(pidx0), 0);
    cyc("s6.u", 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h300);
    peek(32'h74);
    chk("s6.idx_74", 32'(pidx1), 0);
    cyc("s6.d", 1'b1, 32'h74, 1'b1, 1'b0, 0, 1'b0, 0);
    peek(32'h58);
    chk("s6.idx_58", 32'(pidx1), 11);
    chk("s6.hit_58", 32'(hit1), 0);
    cyc("s6.e", 1'b1, 32'h58, 1'b1, 1'b0, 0, 1'b0, 0);

    // Randomised traffic over a small PC pool so entries alias and hit.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc, upc, utgt;
      lpc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      upc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      utgt = $urandom & 32'hFFFF_FFFC;
      cyc($sformatf("rnd%0d", n), 1'b1, lpc, ($urandom_range(0, 99) != 0),
          ($urandom_range(0, 9) < 7), upc, 1'($urandom_range(0, 1)), utgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_predictor_gshare.md
Name: br_predictor_gshare

Overview:
Parametrised branch predictor for the pipelined MIPS core. It is the successor to the fixed 16-entry untagged predictor. It holds a tagged branch target buffer with configurable depth, per-entry saturating counters of configurable width, and a MODE switch between bimodal and gshare (global-history XOR) indexing. Fetch does a combinational lookup. Branch resolution in the MEM stage does a registered update.

Parameters:
PC_W, 32, PC/target width
ENTRIES, 16, table depth; power of two, minimum 2
IDX_W, $clog2(ENTRIES), index width (derived)
TAG_W, 8, tag width
CTR_W, 2, counter width; minimum 1
MODE, 0, 0 = bimodal, 1 = gshare
GHR_W, IDX_W, global history length; must be <= IDX_W

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-low
lookup_pc  in  PC_W  fetch PC
predict_hit  out  1  valid entry with matching tag
predict_taken  out  1  predict taken
predict_target  out  PC_W  predicted target
predict_index  out  IDX_W  index used; carried down the pipeline
update_valid  in  1  resolved branch this cycle
update_pc  in  PC_W  PC of the resolved branch
update_index  in  IDX_W  predict_index captured at that branch's lookup
update_taken  in  1  actual outcome
update_target  in  PC_W  actual taken target

Behaviour:
- Reset is synchronous and active-low on CLK/nRST. When nRST=0 at a rising edge:
  - all valid bits cleared, tags and targets set to 0;
  - all counters set to weak-not-taken, i.e. 2^(CTR_W-1)-1 (01 for CTR_W=2);
  - GHR cleared;
  - any update_valid in that cycle is ignored.
- Index field: pc[IDX_W+1:2]. Tag field: pc[TAG_W+IDX_W+1:IDX_W+2].
- predict_index = index field in MODE 0; index field XOR zero-extended GHR in MODE 1.
- Lookup is purely combinational, zero latency:
  - predict_hit = valid[idx] & (tag[idx] == lookup tag);
  - predict_taken = predict_hit & ctr[idx] MSB;
  - predict_target = target[idx] when predict_hit, else 0.
- After reset, all outputs read 0 for any lookup_pc.
- Update is registered, visible from the next cycle. It writes at update_index. The update tag is taken from update_pc.
  - Hit, taken: counter increments, saturating at 2^CTR_W-1. Target is overwritten with update_target.
  - Hit, not taken: counter decrements, saturating at 0. Target is unchanged.
  - Miss (invalid or tag mismatch), taken: allocate. Set valid=1, write tag and target, counter = weak-taken 2^(CTR_W-1). This replaces any aliased entry.
  - Miss, not taken: no table change.
- GHR (MODE 1 only): on every update_valid, GHR <= {GHR[GHR_W-2:0], update_taken}. GHR is non-speculative. In MODE 0 the GHR logic is held at 0 and may be optimised away.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents in that cycle and the new contents from the next cycle. There is no bypass.
- Target width: targets are stored full PC_W. No arithmetic is performed on them.
- Storage is flops, not RAM, so the table can be cleared in a single cycle.

Decomposition:
- Package bp_pkg holds:
  - bp_entry_t struct: valid, tag[TAG_W], target[PC_W], ctr[CTR_W];
  - constants CTR_WEAK_NT and CTR_WEAK_T as functions of CTR_W;
  - index/tag extraction functions.
- Sub-module bp_sat_ctr: a combinational next-counter calculation, taking ctr and taken and returning the saturating next value. It is instantiated once on the update path.

Test Plan:
1. Reset, then lookup_pc=0x40 -> predict_hit=0, predict_taken=0, predict_target=0, predict_index=0.
2. Update pc=0x40, index=0, taken=1, target=0x100. Next cycle, lookup 0x40 -> hit=1, taken=1, target=0x100, ctr=10.
3. From state 2, apply three not-taken updates at pc 0x40. Counter goes 10->01->00->00. Lookup gives hit=1, taken=0 after the first update. The counter stays at 00 (no wrap).
4. Aliasing: with 0x40 allocated (index 0, tag 0x01), lookup 0x440 (index 0, tag 0x11) -> hit=0. Update 0x440 taken, target 0x200. Then lookup 0x40 -> hit=0; lookup 0x440 -> hit=1, target 0x200.
5. Same cycle: lookup 0x40 and update 0x40 not-taken with ctr=11. That cycle taken=1; next cycle ctr=10, still taken=1. Repeat with nRST=0 in the update cycle -> table cleared and update discarded.
6. MODE=1, GHR_W=4: apply updates taken, taken, not-taken (GHR=0110). Lookup 0x40 -> predict_index=6. Update with update_index=6 taken, target 0x300. Next cycle (GHR=1101), lookup 0x74 (index field 13) -> predict_index=0. Lookup 0x58 (index field 6) -> predict_index=11, hit=0.
